// File: rtl/if_pkg.sv
// Shared types and default widths for the instruction-fetch stage.
package if_pkg;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;
  localparam int PC_STEP     = DEF_INSTR_W / 8;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_stage_prefetch_if.sv
// Instruction-memory request/response bundle between the fetch stage (master) and memory (slave).
interface if_stage_prefetch_if import if_pkg::*; #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
);
  // Request transfers on a clock edge where req_valid && req_ready; req_valid may not depend on
  // req_ready. Responses return in request order, one per rsp_valid cycle, with no backpressure.
  logic               req_valid;
  logic               req_ready;
  logic [ADDR_W-1:0]  req_addr;
  logic               rsp_valid;
  logic [INSTR_W-1:0] rsp_data;

  modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc,instr} entries; head is presented directly from storage.
module fetch_queue import if_pkg::*; #(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  T                           din,
  output T                           dout,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [$clog2(DEPTH+1)-1:0] DEPTH_C = ($clog2(DEPTH+1))'(DEPTH);

  T             mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  // Empty head reads as zero so ID never sees leftover entries after a flush.
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/if_stage_prefetch.sv
// Prefetching IF stage: issues sequential fetches under a credit limit, queues live responses
// and discards responses belonging to requests issued before the last redirect.
module if_stage_prefetch import if_pkg::*; #(
  parameter int               ADDR_W   = DEF_ADDR_W,
  parameter int               INSTR_W  = DEF_INSTR_W,
  parameter int               DEPTH    = 4,
  parameter int               MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_addr,
  if_stage_prefetch_if.master imem,
  output logic                out_valid,
  output logic [ADDR_W-1:0]   out_pc,
  output logic [INSTR_W-1:0]  out_instr
);
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int OW   = $clog2(MAX_OUT + 1);
  localparam int SW   = $clog2(DEPTH + MAX_OUT + 1);
  localparam int AW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int STEP = INSTR_W / 8;

  logic [ADDR_W-1:0] fetch_pc;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     drop_cnt;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] addr_fifo [MAX_OUT];
  logic [AW-1:0]     af_wr;
  logic [AW-1:0]     af_rd;
  logic [SW-1:0]     occupancy;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic              q_full;
  entry_t            q_din;
  entry_t            q_dout;

  function automatic logic [AW-1:0] af_next(input logic [AW-1:0] p);
    return (p == AW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Queue slots already promised: entries held plus live (non-dropped) requests in flight.
  assign occupancy = SW'(count) + SW'(outstanding) - SW'(drop_cnt);

  assign imem.req_valid = !rst && !branch_taken && (outstanding < OW'(MAX_OUT)) &&
                          (occupancy < SW'(DEPTH));
  assign imem.req_addr  = fetch_pc;
  assign req_fire       = imem.req_valid && imem.req_ready;
  assign push           = imem.rsp_valid && (drop_cnt == '0) && !branch_taken;
  assign pop            = out_valid && !freeze;
  assign q_din          = '{pc: addr_fifo[af_rd], instr: imem.rsp_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      af_wr       <= '0;
      af_rd       <= '0;
    end else begin
      if (branch_taken)  fetch_pc <= branch_addr;
      else if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(STEP);

      case ({req_fire, imem.rsp_valid})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: ;
      endcase

      // Every request still in flight at a redirect is stale, including one answering now.
      if (branch_taken)                          drop_cnt <= outstanding - OW'(imem.rsp_valid);
      else if (imem.rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);

      if (req_fire)       af_wr <= af_next(af_wr);
      if (imem.rsp_valid) af_rd <= af_next(af_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) addr_fifo[af_wr] <= fetch_pc;
  end

  fetch_queue #(.T(entry_t), .DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clr   (branch_taken),
    .push  (push),
    .pop   (pop),
    .din   (q_din),
    .dout  (q_dout),
    .valid (out_valid),
    .full  (q_full),
    .count (count)
  );

  assign out_pc    = q_dout.pc;
  assign out_instr = q_dout.instr;

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && q_full && !pop));
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
                                   !(imem.rsp_valid && outstanding == '0));
  a_drop_bound:   assert property (@(posedge clk) disable iff (rst) drop_cnt <= outstanding);
endmodule

// File: tb/tb_if_stage_prefetch.sv
// Bench for if_stage_prefetch: variable-latency memory model, epoch-tagged reference queue,
// a cycle table for the basic flow, directed corner sequences and a randomized run.
module tb_if_stage_prefetch;
  import if_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] STEP     = 32'(PC_STEP);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  if_stage_prefetch_if #(.ADDR_W(32), .INSTR_W(32)) imem ();

  if_stage_prefetch #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (imem),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_instr    (out_instr)
  );

  always #5 clk = ~clk;

  // ---------------- reference state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } pend_t;

  typedef struct {
    logic        fz;
    logic        br;
    logic [31:0] ba;
    logic        req;
    logic        ov;
    logic [31:0] pc;
  } vec_t;

  pend_t       pend_q[$];
  logic [63:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          n_pop = 0;
  logic [31:0] next_addr = RESET_PC;
  logic        popped;
  logic [31:0] popped_pc;
  logic        last_req;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A0F};
  endfunction

  function automatic vec_t mkv(input logic fz, input logic br, input logic [31:0] ba,
                               input logic rq, input logic ov, input logic [31:0] pc);
    vec_t v;
    v.fz = fz; v.br = br; v.ba = ba; v.req = rq; v.ov = ov; v.pc = pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- clock/reset ----------------
  task automatic do_reset();
    rst = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    imem.rsp_valid = 1'b0;
    imem.rsp_data = '0;
    pend_q.delete();
    exp_q.delete();
    next_addr = RESET_PC;
    @(negedge clk);
    check("rst_req_valid", 64'(imem.req_valid), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_pc", 64'(out_pc), 64'(0));
    check("rst_out_instr", 64'(out_instr), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  // One clock: called at a negedge with freeze/branch already set; returns at the next negedge.
  task automatic tick();
    logic rv_s, fire, rsp, pop, br, exp_req;
    logic [31:0] ra_s;
    int live;
    pend_t p;
    check("model_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("model_out_pc", 64'(out_pc), 64'(exp_q[0][63:32]));
      check("model_out_instr", 64'(out_instr), 64'(exp_q[0][31:0]));
    end
    if (pend_q.size() != 0 && pend_q[0].due <= cyc + 1) begin
      imem.rsp_valid = 1'b1;
      imem.rsp_data  = mem_data(pend_q[0].addr);
    end else begin
      imem.rsp_valid = 1'b0;
      imem.rsp_data  = '0;
    end
    #1;
    live = 0;
    foreach (pend_q[i]) if (pend_q[i].epoch == epoch) live++;
    exp_req = !branch_taken && (pend_q.size() < MAX_OUT) && ((exp_q.size() + live) < DEPTH);
    check("model_req_valid", 64'(imem.req_valid), 64'(exp_req));
    if (imem.req_valid) check("model_req_addr", 64'(imem.req_addr), 64'(next_addr));
    rv_s = imem.req_valid;
    ra_s = imem.req_addr;
    last_req  = rv_s;
    last_addr = ra_s;
    fire = rv_s && imem.req_ready;
    rsp  = imem.rsp_valid;
    br   = branch_taken;
    pop  = (exp_q.size() != 0) && !freeze;
    popped = pop;
    popped_pc = pop ? exp_q[0][63:32] : '0;
    @(posedge clk);
    cyc++;
    if (pop) begin
      void'(exp_q.pop_front());
      n_pop++;
    end
    if (rsp) begin
      p = pend_q.pop_front();
      if (!br && p.epoch == epoch) exp_q.push_back({p.addr, mem_data(p.addr)});
    end
    if (br) begin
      exp_q.delete();
      epoch++;
      next_addr = branch_addr;
    end
    if (fire) begin
      pend_q.push_back('{ra_s, cyc + $urandom_range(lat_max, lat_min), epoch});
      next_addr = next_addr + STEP;
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  vec_t        vecs[18];
  logic [31:0] pcs[4];
  logic [31:0] wrap_exp[4];
  int          guard;
  int          got;

  initial begin
    imem.req_ready = 1'b1;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = '0;
    //               fz    br    addr        req   ov    pc
    vecs[0]  = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 32'h0);
    vecs[1]  = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h0);
    vecs[2]  = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h4);
    vecs[3]  = mkv(1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h4);
    vecs[4]  = mkv(1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h4);
    vecs[5]  = mkv(1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h4);
    vecs[6]  = mkv(1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h4);
    vecs[7]  = mkv(1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h8);
    vecs[8]  = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'hC);
    vecs[9]  = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h10);
    vecs[10] = mkv(1'b0, 1'b1, 32'h100,   1'b0, 1'b0, 32'h0);
    vecs[11] = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 32'h0);
    vecs[12] = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h100);
    vecs[13] = mkv(1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 32'h100);
    vecs[14] = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h104);
    vecs[15] = mkv(1'b1, 1'b1, 32'h200,   1'b0, 1'b0, 32'h0);
    vecs[16] = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 32'h0);
    vecs[17] = mkv(1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 32'h200);
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    wrap_exp[3] = 32'h0000_0004;

    // Latency-1 stream, freeze fill, redirect with pop+response, redirect with freeze.
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 18; i++) begin
      freeze = vecs[i].fz;
      branch_taken = vecs[i].br;
      branch_addr = vecs[i].ba;
      tick();
      check($sformatf("vec%0d_req_valid", i), 64'(last_req), 64'(vecs[i].req));
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
      if (vecs[i].ov) check($sformatf("vec%0d_out_pc", i), 64'(out_pc), 64'(vecs[i].pc));
    end
    freeze = 1'b0;
    branch_taken = 1'b0;

    // Redirect with two requests in flight at latency 3.
    do_reset();
    lat_min = 3; lat_max = 3;
    guard = 0;
    while (pend_q.size() < 2 && guard < 20) begin tick(); guard++; end
    check("t3_two_inflight", 64'(pend_q.size()), 64'(2));
    branch_taken = 1'b1; branch_addr = 32'h100;
    tick();
    branch_taken = 1'b0;
    got = 0; guard = 0;
    while (got < 2 && guard < 40) begin
      tick();
      if (popped) begin pcs[got] = popped_pc; got++; end
      guard++;
    end
    check("t3_pops_seen", 64'(got), 64'(2));
    check("t3_first_pc", 64'(pcs[0]), 64'(32'h100));
    check("t3_second_pc", 64'(pcs[1]), 64'(32'h104));

    // Address wrap past 0xFFFFFFFC.
    do_reset();
    lat_min = 1; lat_max = 2;
    for (int i = 0; i < 3; i++) tick();
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFF8;
    tick();
    branch_taken = 1'b0;
    got = 0; guard = 0;
    while (got < 4 && guard < 60) begin
      tick();
      if (popped) begin pcs[got] = popped_pc; got++; end
      guard++;
    end
    check("t5_pops_seen", 64'(got), 64'(4));
    for (int i = 0; i < 4; i++) check($sformatf("t5_wrap_pc%0d", i), 64'(pcs[i]), 64'(wrap_exp[i]));

    // Reset in the middle of a burst.
    do_reset();
    lat_min = 3; lat_max = 3;
    freeze = 1'b1;
    guard = 0;
    while (!(exp_q.size() >= 2 && pend_q.size() >= 1) && guard < 40) begin tick(); guard++; end
    check("t6_burst_state", 64'(exp_q.size() >= 2 && pend_q.size() >= 1), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("t6_out_valid", 64'(out_valid), 64'(0));
    check("t6_out_pc", 64'(out_pc), 64'(0));
    check("t6_out_instr", 64'(out_instr), 64'(0));
    check("t6_req_valid", 64'(imem.req_valid), 64'(0));
    imem.rsp_valid = 1'b0;
    pend_q.delete();
    exp_q.delete();
    next_addr = RESET_PC;
    freeze = 1'b0;
    lat_min = 1; lat_max = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    tick();
    check("t6_restart_req", 64'(last_req), 64'(1));
    check("t6_restart_addr", 64'(last_addr), 64'(RESET_PC));
    for (int i = 0; i < 20; i++) tick();

    // Randomized traffic.
    do_reset();
    lat_min = 1; lat_max = 4;
    n_pop = 0;
    for (int i = 0; i < 3000; i++) begin
      freeze = ($urandom_range(0, 3) == 0);
      imem.req_ready = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 24) == 0);
      branch_addr = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) branch_addr = 32'hFFFF_FFF0 | (branch_addr & 32'hC);
      tick();
    end
    branch_taken = 1'b0;
    freeze = 1'b0;
    imem.req_ready = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    check("rand_progress", 64'(n_pop > 200), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
